pcie_tx_arb: RTL and testbench
==============================

PCIE_TX_ARB -- requirements
Module: pcie_tx_arb

Interface
REQ-001 SHALL have one parameter: COUNT_W, 16, width of the forwarded-packet counter.
REQ-002 SHALL have port clock, input, 1, the single clock for all logic (PCIe user clock).
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports rN_valid, input, 1 each (N=0..2), requester N beat valid.
REQ-005 SHALL have ports rN_data, input, 64 each, requester N beat data.
REQ-006 SHALL have ports rN_1dw, input, 1 each, requester N beat carries only the low 32 bits (final beat only).
REQ-007 SHALL have ports rN_last, input, 1 each, requester N final beat of TLP.
REQ-008 SHALL have ports rN_ready, output, 1 each, beat accepted from N when rN_valid && rN_ready.
REQ-009 SHALL have ports s_axis_tx_tvalid/tdata/1dw/tlast, output, 1/64/1/1, TX stream to the PCIe core.
REQ-010 SHALL have port s_axis_tx_tready, input, 1, core ready; beat transfers when tvalid && tready.
REQ-011 SHALL have port busy, output, 1, high while a requester is granted or the output stage holds data.
REQ-012 SHALL have port pkt_count, output, COUNT_W, number of tlast beats transferred to the core, wrapping.

Function
REQ-013 SHALL arbitrate at TLP granularity; once granted, a requester keeps the grant until its rN_last beat is accepted.
REQ-014 SHALL implement states IDLE and BUSY with a 2-bit registered grant index g and a 2-bit round-robin pointer p.
REQ-015 In IDLE, SHALL select the first N with rN_valid high, searching p, p+1, p+2 mod 3; SHALL load g and enter BUSY on the next edge; no beat is accepted in IDLE.
REQ-016 In BUSY, SHALL drive rg_ready = ~skid_valid; all other rN_ready SHALL be 0; in IDLE all rN_ready SHALL be 0.
REQ-017 On acceptance of a beat with rg_last=1, SHALL return to IDLE and set p = (g+1) mod 3 on the same edge.
REQ-018 Packet overhead SHALL be exactly one IDLE cycle between consecutive grants; within a packet, throughput SHALL be one beat per cycle when tready is held high.
REQ-019 SHALL register output through a 2-entry stage: output register O drives s_axis_tx_*; skid register S captures an accepted beat when O is valid and not draining.
REQ-020 Latency from beat acceptance to s_axis_tx_tvalid SHALL be one cycle when O is empty or draining.
REQ-021 When tready is low and O is valid, O SHALL hold data/1dw/tlast stable; a newly accepted beat SHALL go to S; rg_ready SHALL then drop the following cycle.
REQ-022 When O drains and S is valid, S SHALL move into O on the same edge; beat order SHALL be preserved; no beat is dropped or duplicated.
REQ-023 s_axis_tx_1dw SHALL be passed unmodified from the accepted beat; the block SHALL NOT inspect TLP headers.
REQ-024 pkt_count SHALL increment by 1 on each transfer with tvalid && tready && tlast, wrapping at 2^COUNT_W.
REQ-025 busy SHALL equal (state==BUSY) | O_valid | S_valid.
REQ-026 A requester deasserting rN_valid mid-packet SHALL stall the grant without timeout; other requesters wait.

Reset
REQ-027 While reset is high at a clock edge: state=IDLE, g=0, p=0, O and S invalid, s_axis_tx_tvalid=0, tlast=0, 1dw=0, tdata=0, all rN_ready=0, pkt_count=0, busy=0.
REQ-028 Reset mid-packet SHALL discard in-flight beats in O and S; the next grant after reset SHALL start searching at requester 0.

Verification
REQ-029 Single requester: r1 sends 3-beat TLP, tready=1 -> grant after 1 IDLE cycle, beats on s_axis_tx 1 cycle after acceptance, pkt_count=1, p=2.
REQ-030 All three request continuously with 2-beat TLPs from reset -> grant order 0,1,2,0,1,2; one IDLE cycle between packets.
REQ-031 tready toggles 1,0,0,1 during 4-beat TLP -> S fills, rg_ready drops, output sequence equals input sequence exactly.
REQ-032 1-beat TLP with r0_1dw=1, r0_last=1 -> s_axis_tx_1dw=1, tlast=1, state returns to IDLE the following cycle.
REQ-033 reset asserted with O and S valid mid-packet -> next cycle tvalid=0, pkt_count=0, busy=0, r0 granted first afterward.
REQ-034 pkt_count at 2^COUNT_W-1 (COUNT_W=4) plus one TLP -> wraps to 0.

Source files
------------

// File: rtl/pcie_tx_arb.sv
// Three-requester TLP-granular round-robin arbiter feeding the PCIe TX stream
// through a two-entry output/skid stage.
module pcie_tx_arb #(
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               r0_valid,
  input  logic [63:0]        r0_data,
  input  logic               r0_1dw,
  input  logic               r0_last,
  output logic               r0_ready,
  input  logic               r1_valid,
  input  logic [63:0]        r1_data,
  input  logic               r1_1dw,
  input  logic               r1_last,
  output logic               r1_ready,
  input  logic               r2_valid,
  input  logic [63:0]        r2_data,
  input  logic               r2_1dw,
  input  logic               r2_last,
  output logic               r2_ready,
  output logic               s_axis_tx_tvalid,
  output logic [63:0]        s_axis_tx_tdata,
  output logic               s_axis_tx_1dw,
  output logic               s_axis_tx_tlast,
  input  logic               s_axis_tx_tready,
  output logic               busy,
  output logic [COUNT_W-1:0] pkt_count
);

  typedef struct packed {
    logic [63:0] data;
    logic        dw1;
    logic        last;
  } beat_t;

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  logic [2:0]       req_valid, req_ready;
  beat_t [2:0]      req_beat;
  state_t           state, state_nx;
  logic [1:0]       g, g_nx, p, p_nx;
  logic [1:0]       c1, c2, pick;
  beat_t            o_beat, s_beat, acc_beat;
  logic             o_valid, s_valid, acc, drain;

  assign req_valid   = {r2_valid, r1_valid, r0_valid};
  assign req_beat[0] = beat_t'({r0_data, r0_1dw, r0_last});
  assign req_beat[1] = beat_t'({r1_data, r1_1dw, r1_last});
  assign req_beat[2] = beat_t'({r2_data, r2_1dw, r2_last});
  assign r0_ready    = req_ready[0];
  assign r1_ready    = req_ready[1];
  assign r2_ready    = req_ready[2];

  // search order p, p+1, p+2 (mod 3)
  assign c1   = inc3(p);
  assign c2   = inc3(c1);
  assign pick = req_valid[p]  ? p  :
                req_valid[c1] ? c1 : c2;

  // only the granted requester may move a beat, and only while the skid slot is free
  assign acc_beat = req_beat[g];
  assign acc      = (state == BUSY) && req_valid[g] && !s_valid;
  assign drain    = o_valid && s_axis_tx_tready;

  always_comb begin
    state_nx  = state;
    g_nx      = g;
    p_nx      = p;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_nx = BUSY;
          g_nx     = pick;
        end
      end
      BUSY: begin
        req_ready[g] = ~s_valid;
        if (acc && acc_beat.last) begin
          state_nx = IDLE;
          p_nx     = inc3(g);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      g         <= '0;
      p         <= '0;
      o_valid   <= 1'b0;
      s_valid   <= 1'b0;
      o_beat    <= '0;
      s_beat    <= '0;
      pkt_count <= '0;
    end else begin
      state <= state_nx;
      g     <= g_nx;
      p     <= p_nx;
      if (drain && o_beat.last) pkt_count <= pkt_count + COUNT_W'(1);
      // acc implies S is empty, so an accepted beat goes to O if it frees up, else parks in S
      if (acc) begin
        if (!o_valid || drain) begin
          o_valid <= 1'b1;
          o_beat  <= acc_beat;
        end else begin
          s_valid <= 1'b1;
          s_beat  <= acc_beat;
        end
      end else if (drain) begin
        o_valid <= s_valid;
        if (s_valid) o_beat <= s_beat;
        s_valid <= 1'b0;
      end
    end
  end

  assign s_axis_tx_tvalid = o_valid;
  assign s_axis_tx_tdata  = o_beat.data;
  assign s_axis_tx_1dw    = o_beat.dw1;
  assign s_axis_tx_tlast  = o_beat.last;
  assign busy             = (state == BUSY) | o_valid | s_valid;

endmodule

// File: tb/tb_pcie_tx_arb.sv
// Scoreboard bench for pcie_tx_arb: accepted beats are queued and must reappear
// on the TX stream in order; grant order and timing are checked per scenario.
module tb_pcie_tx_arb;
  localparam int CW = 4;

  typedef struct packed {
    logic [63:0] d;
    logic        dw;
    logic        last;
  } beat_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          tready = 1'b1;
  logic          rv [3];
  logic          r1 [3];
  logic          rl [3];
  logic          rr [3];
  logic [63:0]   rd [3];
  logic          tvalid, t1dw, tlast, busy;
  logic [63:0]   tdata;
  logic [CW-1:0] pkt_count;

  beat_t         src [3][$];
  beat_t         sb [$];
  int            gq [$];
  int            acc_cyc [$];
  bit            in_pkt [3];
  logic [CW-1:0] exp_cnt = '0;
  int            cyc = 0;
  int            pk_id = 0;
  int            errors = 0;
  int            checks = 0;

  pcie_tx_arb #(.COUNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .r0_valid(rv[0]), .r0_data(rd[0]), .r0_1dw(r1[0]), .r0_last(rl[0]), .r0_ready(rr[0]),
    .r1_valid(rv[1]), .r1_data(rd[1]), .r1_1dw(r1[1]), .r1_last(rl[1]), .r1_ready(rr[1]),
    .r2_valid(rv[2]), .r2_data(rd[2]), .r2_1dw(r1[2]), .r2_last(rl[2]), .r2_ready(rr[2]),
    .s_axis_tx_tvalid(tvalid), .s_axis_tx_tdata(tdata), .s_axis_tx_1dw(t1dw),
    .s_axis_tx_tlast(tlast), .s_axis_tx_tready(tready),
    .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clock = ~clock;

  // requester drivers: present the head of each source queue, pop it once accepted
  initial begin
    bit took [3];
    for (int n = 0; n < 3; n++) begin
      rv[n] = 1'b0; rd[n] = '0; r1[n] = 1'b0; rl[n] = 1'b0;
    end
    forever begin
      @(negedge clock);
      for (int n = 0; n < 3; n++) took[n] = rv[n] && rr[n];
      @(posedge clock); #1;
      for (int n = 0; n < 3; n++) begin
        if (took[n] && src[n].size() > 0) void'(src[n].pop_front());
        if (src[n].size() > 0) begin
          rv[n] = 1'b1;
          {rd[n], r1[n], rl[n]} = src[n][0];
        end else begin
          rv[n] = 1'b0; rd[n] = '0; r1[n] = 1'b0; rl[n] = 1'b0;
        end
      end
    end
  end

  // scoreboard: pop on TX transfer, push on requester acceptance
  always @(negedge clock) begin
    beat_t e;
    cyc++;
    if (reset) begin
      sb.delete();
      exp_cnt = '0;
      for (int n = 0; n < 3; n++) in_pkt[n] = 1'b0;
    end else begin
      checks++;
      if (int'(rr[0]) + int'(rr[1]) + int'(rr[2]) > 1) begin
        errors++; $display("FAIL ready_onehot: got %b%b%b expected at most one", rr[2], rr[1], rr[0]);
      end
      if (tvalid && tready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL extra_beat: got %h expected no beat", tdata);
        end else begin
          e = sb.pop_front();
          if ({tdata, t1dw, tlast} !== e) begin
            errors++; $display("FAIL beat: got %h/%b/%b expected %h/%b/%b", tdata, t1dw, tlast, e.d, e.dw, e.last);
          end
          if (e.last) exp_cnt++;
        end
      end
      for (int n = 0; n < 3; n++) begin
        if (rv[n] && rr[n]) begin
          sb.push_back(beat_t'({rd[n], r1[n], rl[n]}));
          acc_cyc.push_back(cyc);
          if (!in_pkt[n]) gq.push_back(n);
          in_pkt[n] = !rl[n];
        end
      end
    end
  end

  function automatic bit quiet();
    return src[0].size() == 0 && src[1].size() == 0 && src[2].size() == 0 &&
           sb.size() == 0 && !busy && !rv[0] && !rv[1] && !rv[2];
  endfunction

  task automatic add_pkt(input int n, input int beats, input bit dw1);
    for (int b = 0; b < beats; b++) begin
      beat_t x;
      x.d    = {8'(n), 8'(pk_id), 8'(b), $urandom(), 8'h5a};
      x.last = (b == beats - 1);
      x.dw   = dw1 && x.last;
      src[n].push_back(x);
    end
    pk_id++;
  endtask

  task automatic pulse_reset();
    @(posedge clock); #2 reset = 1'b1;
    @(posedge clock); #2 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b expected 0", tvalid); end
    checks++; if (tdata !== 64'd0) begin errors++; $display("FAIL rst_tdata: got %h expected 0", tdata); end
    checks++; if ({t1dw, tlast} !== 2'b00) begin errors++; $display("FAIL rst_1dw_last: got %b%b expected 00", t1dw, tlast); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (pkt_count !== '0) begin errors++; $display("FAIL rst_count: got %0d expected 0", pkt_count); end
    checks++; if ({rr[0], rr[1], rr[2]} !== 3'b000) begin errors++; $display("FAIL rst_ready: got %b%b%b expected 000", rr[2], rr[1], rr[0]); end
    @(posedge clock); #2 reset = 1'b0;
  endtask

  task automatic test_single();
    beat_t b0;
    @(negedge clock);
    add_pkt(1, 3, 1'b0);
    b0 = src[1][0];
    @(negedge clock);
    checks++; if (rr[1] !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got ready=%b busy=%b expected 0/0", rr[1], busy); end
    @(negedge clock);
    checks++; if (rr[1] !== 1'b1 || busy !== 1'b1 || tvalid !== 1'b0) begin errors++; $display("FAIL single_grant: got ready=%b busy=%b tvalid=%b expected 1/1/0", rr[1], busy, tvalid); end
    @(negedge clock);
    checks++; if (tvalid !== 1'b1 || tdata !== b0.d) begin errors++; $display("FAIL single_latency: got %b/%h expected 1/%h", tvalid, tdata, b0.d); end
    for (int i = 0; i < 400 && !quiet(); i++) @(negedge clock);
    checks++; if (!quiet()) begin errors++; $display("FAIL single_drain: got busy=%b sb=%0d expected idle", busy, sb.size()); end
    checks++; if (pkt_count !== CW'(1)) begin errors++; $display("FAIL single_count: got %0d expected 1", pkt_count); end
    // pointer now at 2, so a three-way request must be served 2,0,1
    gq.delete();
    add_pkt(0, 1, 1'b0); add_pkt(1, 1, 1'b0); add_pkt(2, 1, 1'b0);
    for (int i = 0; i < 400 && !quiet(); i++) @(negedge clock);
    checks++;
    if (gq.size() != 3) begin errors++; $display("FAIL single_ptr: got %0d grants expected 3", gq.size()); end
    else if (gq[0] != 2 || gq[1] != 0 || gq[2] != 1) begin
      errors++; $display("FAIL single_ptr: got %0d,%0d,%0d expected 2,0,1", gq[0], gq[1], gq[2]);
    end
  endtask

  task automatic test_round_robin();
    int exp_g [6] = '{0, 1, 2, 0, 1, 2};
    pulse_reset();
    gq.delete(); acc_cyc.delete();
    for (int k = 0; k < 2; k++)
      for (int n = 0; n < 3; n++) add_pkt(n, 2, 1'b0);
    for (int i = 0; i < 400 && !quiet(); i++) @(negedge clock);
    checks++; if (!quiet()) begin errors++; $display("FAIL rr_drain: got busy=%b expected idle", busy); end
    checks++; if (gq.size() != 6) begin errors++; $display("FAIL rr_grants: got %0d expected 6", gq.size()); end
    for (int k = 0; k < 6 && k < gq.size(); k++) begin
      checks++; if (gq[k] != exp_g[k]) begin errors++; $display("FAIL rr_order%0d: got %0d expected %0d", k, gq[k], exp_g[k]); end
    end
    checks++;
    if (acc_cyc.size() != 12 || acc_cyc[acc_cyc.size()-1] - acc_cyc[0] != 16) begin
      errors++; $display("FAIL rr_gap: got %0d beats span %0d expected 12 beats span 16",
                         acc_cyc.size(), acc_cyc.size() > 0 ? acc_cyc[acc_cyc.size()-1] - acc_cyc[0] : -1);
    end
  endtask

  task automatic test_backpressure();
    beat_t b [4];
    logic  tr_pat [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic  rdy_exp [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int    dat_idx [5] = '{0, 0, 1, 1, 1};
    pulse_reset();
    tready = 1'b1;
    add_pkt(0, 4, 1'b0);
    for (int k = 0; k < 4; k++) b[k] = src[0][k];
    for (int i = 0; i < 20 && rr[0] !== 1'b1; i++) @(negedge clock);
    checks++; if (rr[0] !== 1'b1) begin errors++; $display("FAIL bp_grant: got ready=%b expected 1", rr[0]); end
    for (int k = 1; k < 5; k++) begin
      @(posedge clock); #2 tready = tr_pat[k];
      @(negedge clock);
      checks++; if (rr[0] !== rdy_exp[k]) begin errors++; $display("FAIL bp_ready%0d: got %b expected %b", k, rr[0], rdy_exp[k]); end
      checks++; if (tvalid !== 1'b1 || tdata !== b[dat_idx[k]].d) begin
        errors++; $display("FAIL bp_hold%0d: got %b/%h expected 1/%h", k, tvalid, tdata, b[dat_idx[k]].d);
      end
    end
    @(posedge clock); #2 tready = 1'b1;
    for (int i = 0; i < 400 && !quiet(); i++) @(negedge clock);
    checks++; if (!quiet()) begin errors++; $display("FAIL bp_drain: got busy=%b sb=%0d expected idle", busy, sb.size()); end
    checks++; if (pkt_count !== CW'(1)) begin errors++; $display("FAIL bp_count: got %0d expected 1", pkt_count); end
  endtask

  task automatic test_one_beat();
    add_pkt(0, 1, 1'b1);
    for (int i = 0; i < 20 && rr[0] !== 1'b1; i++) @(negedge clock);
    checks++; if (rr[0] !== 1'b1) begin errors++; $display("FAIL one_grant: got ready=%b expected 1", rr[0]); end
    @(negedge clock);
    checks++; if ({tvalid, t1dw, tlast} !== 3'b111) begin errors++; $display("FAIL one_flags: got %b%b%b expected 111", tvalid, t1dw, tlast); end
    checks++; if (rr[0] !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL one_idle: got ready=%b busy=%b expected 0/1", rr[0], busy); end
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL one_done: got busy=%b expected 0", busy); end
    checks++; if (pkt_count !== CW'(2)) begin errors++; $display("FAIL one_count: got %0d expected 2", pkt_count); end
  endtask

  task automatic test_reset_mid();
    tready = 1'b0;
    add_pkt(1, 4, 1'b0);
    for (int i = 0; i < 20 && rr[1] !== 1'b1; i++) @(negedge clock);
    @(negedge clock);
    checks++; if (rr[1] !== 1'b1 || tvalid !== 1'b1) begin errors++; $display("FAIL mid_fill: got ready=%b tvalid=%b expected 1/1", rr[1], tvalid); end
    @(posedge clock); #2;
    checks++; if (rr[1] !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mid_skid: got ready=%b busy=%b expected 0/1", rr[1], busy); end
    reset = 1'b1;
    for (int n = 0; n < 3; n++) src[n].delete();
    @(posedge clock); #2 reset = 1'b0; tready = 1'b1;
    @(negedge clock);
    checks++; if (tvalid !== 1'b0 || tdata !== 64'd0) begin errors++; $display("FAIL mid_tvalid: got %b/%h expected 0/0", tvalid, tdata); end
    checks++; if (pkt_count !== '0 || busy !== 1'b0) begin errors++; $display("FAIL mid_state: got count=%0d busy=%b expected 0/0", pkt_count, busy); end
    gq.delete();
    add_pkt(2, 1, 1'b0); add_pkt(0, 1, 1'b0);
    for (int i = 0; i < 400 && !quiet(); i++) @(negedge clock);
    checks++;
    if (gq.size() != 2 || gq[0] != 0 || gq[1] != 2) begin
      errors++; $display("FAIL mid_regrant: got %0d grants first %0d expected 2 grants 0,2", gq.size(), gq.size() > 0 ? gq[0] : -1);
    end
    checks++; if (pkt_count !== CW'(2)) begin errors++; $display("FAIL mid_count: got %0d expected 2", pkt_count); end
  endtask

  task automatic test_wrap();
    pulse_reset();
    for (int k = 0; k < 15; k++) add_pkt(2, 1, 1'b0);
    for (int i = 0; i < 400 && !quiet(); i++) @(negedge clock);
    checks++; if (pkt_count !== CW'(15)) begin errors++; $display("FAIL wrap_max: got %0d expected 15", pkt_count); end
    add_pkt(2, 1, 1'b0);
    for (int i = 0; i < 400 && !quiet(); i++) @(negedge clock);
    checks++; if (pkt_count !== '0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", pkt_count); end
    checks++; if (pkt_count !== exp_cnt) begin errors++; $display("FAIL wrap_model: got %0d expected %0d", pkt_count, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_one_beat();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected summary before time limit");
    $fatal(1, "watchdog");
  end

endmodule
